// File: rtl/simd_operand_fetch.sv
// Vector RF + scoreboard issue stage for the 4-lane SIMD ALU: 1-cycle accept to alu_valid, alu_* hold while alu_ready=0.
// Define SIMD_FETCH_BYPASS_EN to let a same-cycle writeback clear the hazard and forward its data into issue.
module simd_operand_fetch #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int LANES    = 4,
  parameter int LANE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [LANES-1:0]         in_mask,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic [REG_AW-1:0]        in_ra,
  input  logic [REG_AW-1:0]        in_rb,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [LANES*LANE_W-1:0]  alu_vec_a,
  output logic [LANES*LANE_W-1:0]  alu_vec_b,
  output logic [LANES-1:0]         alu_mask,
  output logic [1:0]               alu_op,
  output logic [REG_AW-1:0]        alu_rd,
  input  logic                     wb_valid,
  input  logic [REG_AW-1:0]        wb_rd,
  input  logic [LANES*LANE_W-1:0]  wb_data,
  input  logic [LANES-1:0]         wb_mask,
  output logic [NUM_REGS-1:0]      pending
);
  localparam int VW = LANES * LANE_W;

  logic [VW-1:0]       r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pending;
  logic                r_alu_valid;
  logic [VW-1:0]       r_alu_vec_a;
  logic [VW-1:0]       r_alu_vec_b;
  logic [LANES-1:0]    r_alu_mask;
  logic [1:0]          r_alu_op;
  logic [REG_AW-1:0]   r_alu_rd;

  logic [NUM_REGS-1:0] w_pend_eff;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_out_free;
  logic                w_hazard;
  logic                w_accept;
  logic [VW-1:0]       w_vec_a;
  logic [VW-1:0]       w_vec_b;

  // Pending view used for the hazard check; with bypass a same-cycle writeback releases its register.
  always_comb begin
    w_pend_eff = r_pending;
`ifdef SIMD_FETCH_BYPASS_EN
    if (wb_valid) w_pend_eff[wb_rd] = 1'b0;
`endif
  end

  assign w_out_free = !r_alu_valid || alu_ready;
  assign w_hazard   = w_pend_eff[in_ra] | w_pend_eff[in_rb] | w_pend_eff[in_rd];
  assign in_ready   = w_out_free && !w_hazard;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_vec_a = r_regs[in_ra];
    w_vec_b = r_regs[in_rb];
`ifdef SIMD_FETCH_BYPASS_EN
    for (int l = 0; l < LANES; l++) begin
      if (wb_valid && wb_mask[l] && (wb_rd == in_ra))
        w_vec_a[l*LANE_W +: LANE_W] = wb_data[l*LANE_W +: LANE_W];
      if (wb_valid && wb_mask[l] && (wb_rd == in_rb))
        w_vec_b[l*LANE_W +: LANE_W] = wb_data[l*LANE_W +: LANE_W];
    end
`endif
  end

  // Clear before set, so a same-edge writeback and issue to one register leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_rd] = 1'b0;
    if (w_accept) w_pending_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else if (wb_valid) begin
      for (int l = 0; l < LANES; l++) begin
        if (wb_mask[l]) r_regs[wb_rd][l*LANE_W +: LANE_W] <= wb_data[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid <= 1'b0;
      r_alu_vec_a <= '0;
      r_alu_vec_b <= '0;
      r_alu_mask  <= '0;
      r_alu_op    <= '0;
      r_alu_rd    <= '0;
    end else if (w_accept) begin
      r_alu_valid <= 1'b1;
      r_alu_vec_a <= w_vec_a;
      r_alu_vec_b <= w_vec_b;
      r_alu_mask  <= in_mask;
      r_alu_op    <= in_op;
      r_alu_rd    <= in_rd;
    end else if (w_out_free) begin
      r_alu_valid <= 1'b0;
    end
  end

  assign alu_valid = r_alu_valid;
  assign alu_vec_a = r_alu_vec_a;
  assign alu_vec_b = r_alu_vec_b;
  assign alu_mask  = r_alu_mask;
  assign alu_op    = r_alu_op;
  assign alu_rd    = r_alu_rd;
  assign pending   = r_pending;

endmodule

// File: tb/tb_simd_operand_fetch.sv
// Directed cycle-table bench for simd_operand_fetch plus hand-written reset sequences.
module tb_simd_operand_fetch;
`ifdef SIMD_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_mask;
  logic [2:0]  in_rd, in_ra, in_rb;
  logic        alu_valid, alu_ready;
  logic [31:0] alu_vec_a, alu_vec_b;
  logic [3:0]  alu_mask;
  logic [1:0]  alu_op;
  logic [2:0]  alu_rd;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  wb_mask;
  logic [7:0]  pending;

  simd_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mask(in_mask),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vec_a(alu_vec_a), .alu_vec_b(alu_vec_b),
    .alu_mask(alu_mask), .alu_op(alu_op), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_mask(wb_mask),
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [3:0]  m;
    logic [2:0]  rd, ra, rb;
    logic        wv;
    logic [2:0]  wrd;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        ar;
    logic        e_rdy;
    logic        e_av;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_m;
    logic [1:0]  e_op;
    logic [2:0]  e_rd;
    logic [7:0]  e_pend;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t row(
    input logic iv, input logic [1:0] op, input logic [3:0] m,
    input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
    input logic wv, input logic [2:0] wrd, input logic [31:0] wd, input logic [3:0] wm,
    input logic ar, input logic e_rdy, input logic e_av,
    input logic [31:0] e_a, input logic [31:0] e_b, input logic [3:0] e_m,
    input logic [1:0] e_op, input logic [2:0] e_rd, input logic [7:0] e_pend);
    vec_t v;
    v.iv = iv; v.op = op; v.m = m; v.rd = rd; v.ra = ra; v.rb = rb;
    v.wv = wv; v.wrd = wrd; v.wd = wd; v.wm = wm; v.ar = ar;
    v.e_rdy = e_rdy; v.e_av = e_av; v.e_a = e_a; v.e_b = e_b;
    v.e_m = e_m; v.e_op = e_op; v.e_rd = e_rd; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; in_op = v.op; in_mask = v.m;
    in_rd = v.rd; in_ra = v.ra; in_rb = v.rb;
    wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wd; wb_mask = v.wm;
    alu_ready = v.ar;
  endtask

  initial begin
    // iv op m rd ra rb | wv wrd wd wm | ar | rdy av a b m op rd pend
    tbl.push_back(row(0,0,0,0,0,0, 1,1,32'h04030201,4'hF, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(0,0,0,0,0,0, 1,2,32'h10101010,4'hF, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(1,0,4'hF,3,1,2, 0,0,0,0, 1, 1,1,32'h04030201,32'h10101010,4'hF,0,3, 8'h08));
    tbl.push_back(row(0,0,0,0,0,0, 1,3,32'hAABBCCDD,4'hF, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(0,0,0,0,0,0, 1,3,32'h11223344,4'h5, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(1,3,4'hA,4,3,3, 0,0,0,0, 1, 1,1,32'hAA22CC44,32'hAA22CC44,4'hA,3,4, 8'h10));
    tbl.push_back(row(1,2,4'hF,5,4,0, 0,0,0,0, 1, 0,0,0,0,0,0,0, 8'h10));
    if (BYP) begin
      tbl.push_back(row(1,2,4'hF,5,4,0, 1,4,32'h55667788,4'h3, 1, 1,1,32'h00007788,0,4'hF,2,5, 8'h20));
      tbl.push_back(row(0,0,0,0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0, 8'h20));
    end else begin
      tbl.push_back(row(1,2,4'hF,5,4,0, 1,4,32'h55667788,4'h3, 1, 0,0,0,0,0,0,0, 8'h00));
      tbl.push_back(row(1,2,4'hF,5,4,0, 0,0,0,0, 1, 1,1,32'h00007788,0,4'hF,2,5, 8'h20));
    end
    tbl.push_back(row(0,0,0,0,0,0, 1,5,0,4'h0, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(1,0,4'hF,5,1,2, 1,5,32'h99999999,4'h1, 1, 1,1,32'h04030201,32'h10101010,4'hF,0,5, 8'h20));
    tbl.push_back(row(0,0,0,0,0,0, 1,5,32'hFFFFFFFF,4'h0, 1, 1,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(1,0,4'hF,6,5,5, 0,0,0,0, 1, 1,1,32'h00000099,32'h00000099,4'hF,0,6, 8'h40));
    tbl.push_back(row(1,0,4'hF,7,1,2, 0,0,0,0, 1, 1,1,32'h04030201,32'h10101010,4'hF,0,7, 8'hC0));
    tbl.push_back(row(1,0,4'hF,0,2,1, 0,0,0,0, 1, 1,1,32'h10101010,32'h04030201,4'hF,0,0, 8'hC1));
    tbl.push_back(row(0,0,0,0,0,0, 1,6,0,4'h0, 1, 0,0,0,0,0,0,0, 8'h81));
    tbl.push_back(row(0,0,0,0,0,0, 1,7,0,4'h0, 1, 0,0,0,0,0,0,0, 8'h01));
    tbl.push_back(row(0,0,0,0,0,0, 1,0,0,4'h0, 1, BYP,0,0,0,0,0,0, 8'h00));
    tbl.push_back(row(1,1,4'h6,1,2,0, 0,0,0,0, 1, 1,1,32'h10101010,0,4'h6,1,1, 8'h02));
    for (int k = 0; k < 3; k++)
      tbl.push_back(row(1,2,4'hF,3,0,2, 0,0,0,0, 0, 0,1,32'h10101010,0,4'h6,1,1, 8'h02));
    tbl.push_back(row(1,2,4'hF,3,0,2, 0,0,0,0, 1, 1,1,0,32'h10101010,4'hF,2,3, 8'h0A));
    tbl.push_back(row(0,0,0,0,0,0, 0,0,0,0, 0, 0,1,0,32'h10101010,4'hF,2,3, 8'h0A));
    tbl.push_back(row(1,0,4'hF,5,0,0, 1,1,0,4'h0, 1, 1,1,0,0,4'hF,0,5, 8'h28));

    rst_n = 1'b0;
    drive(row(0,0,0,0,0,0, 0,0,0,0, 1, 0,0,0,0,0,0,0, 0));
    #3;
    chk("reset alu_valid", alu_valid, 0);
    chk("reset alu_vec_a", alu_vec_a, 0);
    chk("reset alu_vec_b", alu_vec_b, 0);
    chk("reset alu_mask", alu_mask, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset alu_rd", alu_rd, 0);
    chk("reset pending", pending, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("row%0d alu_valid", i), alu_valid, tbl[i].e_av);
      if (tbl[i].e_av) begin
        chk($sformatf("row%0d alu_vec_a", i), alu_vec_a, tbl[i].e_a);
        chk($sformatf("row%0d alu_vec_b", i), alu_vec_b, tbl[i].e_b);
        chk($sformatf("row%0d alu_mask", i), alu_mask, tbl[i].e_m);
        chk($sformatf("row%0d alu_op", i), alu_op, tbl[i].e_op);
        chk($sformatf("row%0d alu_rd", i), alu_rd, tbl[i].e_rd);
      end
      chk($sformatf("row%0d pending", i), pending, tbl[i].e_pend);
    end

    // Mid-operation reset with alu_valid=1 and pending=0x28.
    chk("pre-reset alu_valid", alu_valid, 1);
    chk("pre-reset pending", pending, 8'h28);
    drive(row(0,0,0,0,0,0, 0,0,0,0, 1, 0,0,0,0,0,0,0, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst alu_valid", alu_valid, 0);
    chk("midrst pending", pending, 0);
    chk("midrst alu_vec_a", alu_vec_a, 0);
    chk("midrst in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(row(1,0,4'hF,2,1,2, 0,0,0,0, 1, 0,0,0,0,0,0,0, 0));
    #1;
    chk("postrst in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("postrst alu_valid", alu_valid, 1);
    chk("postrst r1 cleared", alu_vec_a, 0);
    chk("postrst r2 cleared", alu_vec_b, 0);
    chk("postrst pending", pending, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
